// File: rtl/axis_merge_if.sv
// axis_merge_if: one AXI-Stream channel carrying valid/ready, data, byte
// strobes and end-of-packet. axis_merge uses one narrow instance on its
// receive side and one wide instance on its transmit side.
interface axis_merge_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;

    // Producer side of the channel.
    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    // Consumer side of the channel.
    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_merge.sv
// axis_merge: 2:1 AXI-Stream width upsizer. Two consecutive narrow beats are
// packed into one wide beat. The first-arriving half waits in a hold
// register; the wide word is formed when the second half arrives and is
// presented from a registered master output.
//
// With ENABLE_TLAST=1 a packet ending on the first half of a pair is padded:
// the beat goes out alone with zeros in the missing half and tlast=1.
//
// Optional feature, macro AXIS_MERGE_ODD_STAT_EN: adds odd_pkt_pulse and a
// saturating 8-bit odd_pkt_count of padded (odd-length packet) loads.
//
// C_M_AXIS_TDATA_WIDTH must equal 2*C_S_AXIS_TDATA_WIDTH; the interface
// instances bound to s_axis/m_axis must use those same data widths.
module axis_merge #(
    parameter bit MSH_FIRST            = 1'b1,
    parameter bit ENABLE_TSTRB         = 1'b0,
    parameter bit ENABLE_TLAST         = 1'b0,
    parameter int C_S_AXIS_TDATA_WIDTH = 16,
    parameter int C_M_AXIS_TDATA_WIDTH = 2 * C_S_AXIS_TDATA_WIDTH
) (
    input  logic         axis_aclk,
    input  logic         axis_areset,
    axis_merge_if.slave  s_axis,
    axis_merge_if.master m_axis
`ifdef AXIS_MERGE_ODD_STAT_EN
    ,
    output logic         odd_pkt_pulse,
    output logic [7:0]   odd_pkt_count
`endif
);

    localparam int SW = C_S_AXIS_TDATA_WIDTH;
    localparam int SS = SW / 8;
    localparam int MW = C_M_AXIS_TDATA_WIDTH;
    localparam int MS = MW / 8;

    // FIRST: hold register empty. LAST: hold register has the first half.
    typedef enum logic {
        FIRST = 1'b0,
        LAST  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [SW-1:0]   hold_data;
    logic [SS-1:0]   hold_strb;
    logic            hold_en;

    logic            out_valid;
    logic [MW-1:0]   out_data;
    logic [MS-1:0]   out_strb;
    logic            out_last;

    logic            load;
    logic [MW-1:0]   load_data;
    logic [MS-1:0]   load_strb;
    logic            load_last;

    logic            out_free;
    logic            s_ready;
    logic            s_hs;
    logic            m_hs;

    // The output register can take a new word when empty or draining now.
    assign out_free = ~out_valid | m_axis.tready;
    assign m_hs     = out_valid & m_axis.tready;

    // Without tlast handling the first half only touches the hold register,
    // so it is accepted even while the output register is stalled. Every
    // other accept may load the output register and must wait for room.
    assign s_ready = (ENABLE_TLAST || state == LAST) ? out_free : 1'b1;
    assign s_hs    = s_axis.tvalid & s_ready;

    assign s_axis.tready = s_ready;

    // Next state, hold capture and output-register load selection.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // leaves one unassigned and no latch can be inferred.
        state_nxt = state;
        hold_en   = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_strb = '0;
        load_last = 1'b0;

        case (state)
            FIRST: begin
                if (s_hs) begin
                    if (ENABLE_TLAST && s_axis.tlast) begin
                        // Odd-length packet: send the lone half, pad the rest.
                        load      = 1'b1;
                        load_last = 1'b1;
                        if (MSH_FIRST) begin
                            load_data = {s_axis.tdata, {SW{1'b0}}};
                        end else begin
                            load_data = {{SW{1'b0}}, s_axis.tdata};
                        end
                        if (!ENABLE_TSTRB) begin
                            load_strb = {MS{1'b1}};
                        end else if (MSH_FIRST) begin
                            load_strb = {s_axis.tstrb, {SS{1'b0}}};
                        end else begin
                            load_strb = {{SS{1'b0}}, s_axis.tstrb};
                        end
                    end else begin
                        hold_en   = 1'b1;
                        state_nxt = LAST;
                    end
                end
            end

            LAST: begin
                if (s_hs) begin
                    load      = 1'b1;
                    load_last = ENABLE_TLAST ? s_axis.tlast : 1'b0;
                    if (MSH_FIRST) begin
                        load_data = {hold_data, s_axis.tdata};
                    end else begin
                        load_data = {s_axis.tdata, hold_data};
                    end
                    if (!ENABLE_TSTRB) begin
                        load_strb = {MS{1'b1}};
                    end else if (MSH_FIRST) begin
                        load_strb = {hold_strb, s_axis.tstrb};
                    end else begin
                        load_strb = {s_axis.tstrb, hold_strb};
                    end
                    state_nxt = FIRST;
                end
            end
        endcase
    end

    // State register; a reset drops any partially received pair.
    always_ff @(posedge axis_aclk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (axis_areset) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold register captures the first-arriving narrow beat.
    always_ff @(posedge axis_aclk) begin
        // NOTE: this data register is cleared on reset on purpose, so the
        // design powers up with a defined, all-zero hold value.
        if (axis_areset) begin
            hold_data <= '0;
            hold_strb <= '0;
        end else if (hold_en) begin
            hold_data <= s_axis.tdata;
            hold_strb <= s_axis.tstrb;
        end
    end

    // Output register: a load wins over a drain; payload only changes on load.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_strb  <= load_strb;
            out_last  <= load_last;
        end else if (m_hs) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tstrb  = out_strb;
    assign m_axis.tlast  = out_last;

`ifdef AXIS_MERGE_ODD_STAT_EN
    // A padded load is any load issued from FIRST; it can only happen when
    // tlast handling is enabled, so both outputs stay 0 otherwise.
    logic       pad_load;
    logic       pulse_q;
    logic [7:0] count_q;

    assign pad_load = load && (state == FIRST);

    // Odd-packet pulse and saturating counter.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            pulse_q <= pad_load;
            if (pad_load && count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign odd_pkt_pulse = pulse_q;
    assign odd_pkt_count = count_q;
`endif

endmodule
